// File: rtl/axil_reg_bank_slave.sv
// AXI4-Lite register bank: NUM_REGS x 32-bit regs exported flat; optional SLVERR on unmapped (AXIL_REGS_SLVERR_EN).
// Latency: B and R valid one cycle after the (last) address/data handshake; writes visible on reg_out next cycle.
// Backpressure: one outstanding write and one read; ready lines drop while a response waits for BREADY/RREADY.
module axil_reg_bank_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          reg_out,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    typedef enum logic [1:0] {W_IDLE, W_AHELD, W_DHELD, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t wstate;
    rstate_t rstate;

    logic [31:0]      regs [NUM_REGS];
    logic [IDX_W-1:0] aw_idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;

    logic             aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0] cm_idx, ar_idx;
    logic [31:0]      cm_data, rd_val;
    logic [3:0]       cm_strb;

    wire unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = (wstate == W_IDLE) || (wstate == W_DHELD);
    assign S_AXI_WREADY  = (wstate == W_IDLE) || (wstate == W_AHELD);
    assign S_AXI_ARREADY = (rstate == R_IDLE);

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    // Commit source: whichever half arrives last comes straight off the bus, the other from the hold regs.
    always_comb begin
        commit  = 1'b0;
        cm_idx  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        cm_data = S_AXI_WDATA;
        cm_strb = S_AXI_WSTRB;
        case (wstate)
            W_IDLE:  commit = aw_hs && w_hs;
            W_AHELD: begin
                commit = w_hs;
                cm_idx = aw_idx_q;
            end
            W_DHELD: begin
                commit  = aw_hs;
                cm_data = wdata_q;
                cm_strb = wstrb_q;
            end
            default: commit = 1'b0;
        endcase
    end

    // Out-of-range indices match no register, so unmapped reads fall out as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) rd_val = regs[i];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate       <= W_IDLE;
            aw_idx_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= 2'b00;
            reg_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            reg_wr_pulse <= '0;
            case (wstate)
                W_IDLE: begin
                    if (aw_hs && !w_hs) begin
                        aw_idx_q <= cm_idx;
                        wstate   <= W_AHELD;
                    end else if (w_hs && !aw_hs) begin
                        wdata_q <= S_AXI_WDATA;
                        wstrb_q <= S_AXI_WSTRB;
                        wstate  <= W_DHELD;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        wstate       <= W_IDLE;
                    end
                end
                default: ;
            endcase
            if (commit) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (cm_idx == IDX_W'(i)) begin
                        reg_wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (cm_strb[b]) regs[i][8*b +: 8] <= cm_data[8*b +: 8];
                        end
                    end
                end
`ifdef AXIL_REGS_SLVERR_EN
                S_AXI_BRESP <= (int'(cm_idx) < NUM_REGS) ? 2'b00 : 2'b10;
`else
                S_AXI_BRESP <= 2'b00;
`endif
                S_AXI_BVALID <= 1'b1;
                wstate       <= W_RESP;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rstate       <= R_IDLE;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= 2'b00;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        S_AXI_RDATA  <= rd_val;
`ifdef AXIL_REGS_SLVERR_EN
                        S_AXI_RRESP  <= (int'(ar_idx) < NUM_REGS) ? 2'b00 : 2'b10;
`else
                        S_AXI_RRESP  <= 2'b00;
`endif
                        S_AXI_RVALID <= 1'b1;
                        rstate       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        rstate       <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_out[32*g +: 32] = regs[g];
    end
endmodule

// File: tb/tb_axil_reg_bank_slave.sv
// Directed bench for axil_reg_bank_slave with a register model and B/R response queues.
module tb_axil_reg_bank_slave;
    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [4:0]   S_AXI_AWADDR = '0;
    logic [2:0]   S_AXI_AWPROT = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA = '0;
    logic [3:0]   S_AXI_WSTRB = '0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY = 1'b0;
    logic [4:0]   S_AXI_ARADDR = '0;
    logic [2:0]   S_AXI_ARPROT = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY = 1'b0;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_pulse;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [4];
    logic [1:0]  bq [$];
    logic [33:0] rq [$];
`ifdef AXIL_REGS_SLVERR_EN
    localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

    axil_reg_bank_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    initial forever #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    // Drives AW and W with independent start delays; returns right after the later handshake edge.
    task automatic axi_write_req(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                                 input int aw_dly, input int w_dly, output int cycles);
        int idx, c, early;
        bit aw_done, w_done, aw_fire, w_fire;
        logic [3:0] exp_pulse;
        idx = int'(a[4:2]);
        exp_pulse = '0;
        if (idx < 4) begin
            exp_pulse[idx] = 1'b1;
            for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            bq.push_back(2'b00);
        end else begin
            bq.push_back(UNMAP_RESP);
        end
        S_AXI_AWADDR = a;
        S_AXI_WDATA  = d;
        S_AXI_WSTRB  = s;
        aw_done = 0; w_done = 0; c = 0; early = 0;
        while (!(aw_done && w_done) && c < 20) begin
            S_AXI_AWVALID = !aw_done && (c >= aw_dly);
            S_AXI_WVALID  = !w_done && (c >= w_dly);
            aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
            w_fire  = S_AXI_WVALID && S_AXI_WREADY;
            if (S_AXI_BVALID) early++;
            tick();
            c++;
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        cycles = c;
        chk("wr_hs_done", {aw_done, w_done}, 2'b11);
        chk("b_early", early, 0);
        chk("b_latency", S_AXI_BVALID, 1'b1);
        chk("wr_pulse", reg_wr_pulse, exp_pulse);
        chk("reg_out_after_wr", reg_out, model_flat());
    endtask

    task automatic b_resp(input int dly);
        logic [1:0] exp;
        chk("bq_nonempty", bq.size() > 0, 1'b1);
        exp = (bq.size() > 0) ? bq.pop_front() : 2'b00;
        chk("bresp", S_AXI_BRESP, exp);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("b_hold_vld", S_AXI_BVALID, 1'b1);
            chk("b_hold_resp", S_AXI_BRESP, exp);
            chk("rdy_in_resp", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
            chk("reg_out_in_resp", reg_out, model_flat());
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        chk("b_done", S_AXI_BVALID, 1'b0);
        chk("pulse_clear", reg_wr_pulse, 4'b0);
        chk("aw_rdy_after_b", S_AXI_AWREADY, 1'b1);
    endtask

    task automatic axi_read(input logic [4:0] a);
        int idx, c;
        bit fired, fire;
        logic [33:0] exp;
        idx = int'(a[4:2]);
        if (idx < 4) rq.push_back({2'b00, model[idx]});
        else rq.push_back({UNMAP_RESP, 32'h0});
        S_AXI_ARADDR = a;
        S_AXI_ARVALID = 1'b1;
        c = 0; fired = 0;
        while (!fired && c < 20) begin
            fire = S_AXI_ARVALID && S_AXI_ARREADY;
            tick();
            c++;
            if (fire) fired = 1;
        end
        S_AXI_ARVALID = 1'b0;
        chk("rd_hs_done", fired, 1'b1);
        chk("r_latency", S_AXI_RVALID, 1'b1);
        exp = rq.pop_front();
        chk("rdata", S_AXI_RDATA, exp[31:0]);
        chk("rresp", S_AXI_RRESP, exp[33:32]);
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        chk("r_done", S_AXI_RVALID, 1'b0);
        chk("ar_rdy_after_r", S_AXI_ARREADY, 1'b1);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 4; i++) model[i] = '0;
        repeat (3) tick();
        ARESET = 1'b0;
        chk("rst_bvalid", S_AXI_BVALID, 1'b0);
        chk("rst_rvalid", S_AXI_RVALID, 1'b0);
        chk("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 4'b0);
        chk("rst_rdata", S_AXI_RDATA, 32'h0);
        chk("rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        chk("rst_reg_out", reg_out, 128'h0);
        chk("rst_pulse", reg_wr_pulse, 4'b0);

        // Basic writes then readback
        for (int i = 0; i < 4; i++) begin
            axi_write_req(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, cyc);
            b_resp(0);
        end
        chk("reg_out_basic", reg_out, 128'h00000004_00000003_00000002_00000001);
        for (int i = 0; i < 4; i++) axi_read(5'(4 * i));
        axi_read(5'h6);

        // AW leads W by 3, then W leads AW by 3
        axi_write_req(5'h4, 32'hDEADBEEF, 4'hF, 0, 3, cyc);
        chk("aw_first_cycles", cyc, 4);
        b_resp(0);
        axi_write_req(5'h4, 32'hDEADBEEF, 4'hF, 3, 0, cyc);
        chk("w_first_cycles", cyc, 4);
        b_resp(0);
        chk("reg1_deadbeef", reg_out[63:32], 32'hDEADBEEF);

        // Byte strobes
        axi_write_req(5'h8, 32'h11223344, 4'hF, 0, 0, cyc);
        b_resp(0);
        axi_write_req(5'h8, 32'hAABBCCDD, 4'b0101, 0, 0, cyc);
        chk("reg2_strobed", reg_out[95:64], 32'h11BB33DD);
        b_resp(0);

        // BREADY held low with a second write waiting
        axi_write_req(5'h0, 32'hCAFE0001, 4'hF, 0, 0, cyc);
        S_AXI_AWADDR  = 5'hC;
        S_AXI_WDATA   = 32'h0BADF00D;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        b_resp(5);
        axi_write_req(5'hC, 32'h0BADF00D, 4'hF, 0, 0, cyc);
        chk("second_aw_cycles", cyc, 1);
        b_resp(0);

        // Reset while write is in W_AHELD and read is in R_DATA
        S_AXI_AWADDR  = 5'h4;
        S_AXI_AWVALID = 1'b1;
        S_AXI_ARADDR  = 5'h0;
        S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_ARVALID = 1'b0;
        chk("ahold_readys", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b01);
        chk("rdata_pending", S_AXI_RVALID, 1'b1);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        chk("mid_rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        chk("mid_rst_regs", reg_out, 128'h0);
        chk("mid_rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        axi_read(5'h4);
        axi_write_req(5'h4, 32'h5A5A5A5A, 4'hF, 0, 0, cyc);
        b_resp(0);

        // Unmapped access
        axi_write_req(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, cyc);
        b_resp(0);
        axi_read(5'h10);
        axi_read(5'h1C);
        chk("unmapped_regs_kept", reg_out, model_flat());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
